// File: rtl/hitor_tdc.sv
// rtl/hitor_tdc.sv - HITOR time-over-threshold stamper emitting 3-word tagged events through a FWFT FIFO
module hitor_tdc #(
    parameter logic [3:0] IDENTIFIER = 4'b0101,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic        HITOR,
    input  logic        FIFO_READ,
    output logic        FIFO_EMPTY,
    output logic [31:0] FIFO_DATA,
    output logic [7:0]  LOST_COUNT,
    output logic [47:0] TIMESTAMP
);
    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = 1;
    localparam logic [AW:0]    CNT_ONE  = 1;
    localparam logic [AW:0]    MAX_FILL = (AW + 1)'(FIFO_DEPTH - 3);

    typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

    state_t        state, state_nxt;
    logic          s1, s2, s3;
    logic          armed;
    logic [47:0]   rise_ts;
    logic [47:0]   hold_ts;
    logic [15:0]   hold_tot;
    logic [9:0]    hold_evt;
    logic [9:0]    evt_cnt;
    logic [47:0]   diff;
    logic [15:0]   tot;
    logic          rise, fall, event_done, space_ok, capture, lose;
    logic          push, pop;
    logic [31:0]   push_data;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    assign rise       = s2 & ~s3;
    assign fall       = ~s2 & s3;
    assign diff       = TIMESTAMP - rise_ts;
    assign tot        = (diff >= 48'h0000_0000_FFFF) ? 16'hFFFF : diff[15:0];
    assign event_done = fall & ENABLE & armed;
    // Three words are reserved up front so W0..W2 never see a full FIFO.
    assign space_ok   = (count <= MAX_FILL);
    assign capture    = event_done & (state == IDLE) & space_ok;
    assign lose       = event_done & ~capture;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            TIMESTAMP  <= '0;
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            armed      <= 1'b0;
            rise_ts    <= '0;
            hold_ts    <= '0;
            hold_tot   <= '0;
            hold_evt   <= '0;
            evt_cnt    <= '0;
            LOST_COUNT <= '0;
        end else begin
            TIMESTAMP <= TIMESTAMP + 48'd1;
            s1        <= HITOR;
            s2        <= s1;
            s3        <= s2;
            if (!ENABLE) begin
                armed <= 1'b0;
            end else if (rise) begin
                rise_ts <= TIMESTAMP;
                armed   <= 1'b1;
            end else if (event_done) begin
                armed <= 1'b0;
            end
            if (capture) begin
                hold_ts  <= rise_ts;
                hold_tot <= tot;
                hold_evt <= evt_cnt;
                evt_cnt  <= evt_cnt + 10'd1;
            end
            if (lose && LOST_COUNT != 8'hFF) begin
                LOST_COUNT <= LOST_COUNT + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_data = '0;
        case (state)
            IDLE: if (capture) state_nxt = W0;
            W0: begin
                push      = 1'b1;
                push_data = {IDENTIFIER, 2'b00, hold_ts[25:0]};
                state_nxt = W1;
            end
            W1: begin
                push      = 1'b1;
                push_data = {IDENTIFIER, 2'b01, hold_ts[47:26], 4'b0000};
                state_nxt = W2;
            end
            W2: begin
                push      = 1'b1;
                push_data = {IDENTIFIER, 2'b10, hold_evt, hold_tot};
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pop        = FIFO_READ & (count != '0);
    assign FIFO_EMPTY = (count == '0);
    assign FIFO_DATA  = FIFO_EMPTY ? 32'h0 : mem[rd_ptr];

    // Storage is not reset; the empty flag masks stale contents on FIFO_DATA.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_hitor_tdc.sv
// tb/tb_hitor_tdc.sv - scoreboard bench for hitor_tdc
module tb_hitor_tdc;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        ENABLE;
    logic        HITOR;
    logic        FIFO_READ;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic [7:0]  LOST_COUNT;
    logic [47:0] TIMESTAMP;

    hitor_tdc #(.IDENTIFIER(4'b0101), .FIFO_DEPTH(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .HITOR(HITOR),
        .FIFO_READ(FIFO_READ), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
        .LOST_COUNT(LOST_COUNT), .TIMESTAMP(TIMESTAMP)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    bit          rd_en = 1'b0;
    int          pops = 0;
    int          exp_evt = 0;
    int          exp_lost = 0;
    logic [47:0] tb_ts;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) tb_ts <= '0;
        else        tb_ts <= tb_ts + 48'd1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push_evt(input logic [47:0] t, input logic [15:0] tot);
        sb.push_back({4'b0101, 2'b00, t[25:0]});
        sb.push_back({4'b0101, 2'b01, t[47:26], 4'b0000});
        sb.push_back({4'b0101, 2'b10, 10'(exp_evt), tot});
        exp_evt = (exp_evt + 1) % 1024;
    endtask

    task automatic lost_inc();
        if (exp_lost < 255) exp_lost++;
    endtask

    // Called at posedge+1; rise is stamped two counts later after the synchronizer.
    task automatic pulse(input int hi, input int lo, input bit cap);
        logic [47:0] t;
        t = tb_ts + 48'd2;
        HITOR = 1'b1;
        step(hi);
        HITOR = 1'b0;
        if (cap) push_evt(t, (hi >= 65535) ? 16'hFFFF : 16'(hi));
        else     lost_inc();
        step(lo);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        rd_en = 1'b1;
        while (!(sb.size() == 0 && FIFO_EMPTY) && n < budget) begin
            step(1);
            n++;
        end
        chk("drain_done", 64'(n < budget), 64'd1);
        step(4);
        chk("empty_after_drain", 64'(FIFO_EMPTY), 64'd1);
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] exp;
        FIFO_READ = 1'b0;
        forever begin
            @(negedge CLK);
            if (rd_en) begin
                if (!FIFO_EMPTY) begin
                    chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        exp = sb.pop_front();
                        chk("word", 64'(FIFO_DATA), 64'(exp));
                    end
                    pops++;
                end
                FIFO_READ = 1'b1;
            end else begin
                FIFO_READ = 1'b0;
            end
        end
    end

    initial begin
        int          p0;
        logic [47:0] t;
        RST_N  = 1'b0;
        ENABLE = 1'b1;
        HITOR  = 1'b0;
        #12;
        chk("rst_empty", 64'(FIFO_EMPTY), 64'd1);
        chk("rst_data", 64'(FIFO_DATA), 64'd0);
        chk("rst_lost", 64'(LOST_COUNT), 64'd0);
        chk("rst_ts", 64'(TIMESTAMP), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        step(1);
        while (tb_ts < 48'd98) step(1);

        // single pulse, exact output latency and literal word values
        pulse(10, 0, 1'b1);
        step(3);
        chk("t1_empty_k1", 64'(FIFO_EMPTY), 64'd1);
        step(1);
        chk("t1_empty_k2", 64'(FIFO_EMPTY), 64'd0);
        chk("t1_w0_lit", 64'(FIFO_DATA), 64'h5000_0064);
        chk("t1_sb_w1", 64'(sb[1]), 64'h5400_0000);
        chk("t1_sb_w2", 64'(sb[2]), 64'h5800_000A);
        chk("t1_ts", 64'(TIMESTAMP), 64'(tb_ts));
        drain(50);

        // ToT saturation then following event count
        pulse(70000, 10, 1'b1);
        pulse(3, 10, 1'b1);
        drain(50);
        chk("t2_ts", 64'(TIMESTAMP), 64'(tb_ts));

        // FIFO fill: third event has no room
        rd_en = 1'b0;
        step(2);
        pulse(5, 12, 1'b1);
        pulse(5, 12, 1'b1);
        pulse(5, 12, 1'b0);
        chk("t3_lost", 64'(LOST_COUNT), 64'(exp_lost));
        chk("t3_nonempty", 64'(FIFO_EMPTY), 64'd0);
        p0 = pops;
        drain(50);
        chk("t3_pops", 64'(pops - p0), 64'd6);

        // back-to-back pulses: second fall lands while FSM is busy
        t = tb_ts + 48'd2;
        HITOR = 1'b1;
        step(1);
        HITOR = 1'b0;
        step(1);
        HITOR = 1'b1;
        step(1);
        HITOR = 1'b0;
        push_evt(t, 16'd1);
        lost_inc();
        step(10);
        chk("t4_lost", 64'(LOST_COUNT), 64'(exp_lost));
        drain(50);

        // ENABLE dropped while HITOR high
        HITOR = 1'b1;
        step(5);
        ENABLE = 1'b0;
        step(3);
        HITOR = 1'b0;
        step(10);
        ENABLE = 1'b1;
        step(10);
        chk("t5_lost_same", 64'(LOST_COUNT), 64'(exp_lost));
        chk("t5_no_words", 64'(FIFO_EMPTY), 64'd1);

        // LOST_COUNT saturation with a nearly full FIFO
        rd_en = 1'b0;
        step(2);
        pulse(5, 12, 1'b1);
        pulse(5, 12, 1'b1);
        for (int i = 0; i < 300; i++) pulse(2, 2, 1'b0);
        step(5);
        chk("t5_lost_sat", 64'(LOST_COUNT), 64'd255);
        chk("t5_lost_model", 64'(LOST_COUNT), 64'(exp_lost));
        drain(50);

        // reset in the middle of an event
        rd_en = 1'b0;
        step(2);
        pulse(4, 0, 1'b1);
        step(4);
        chk("t6_pre_rst_nonempty", 64'(FIFO_EMPTY), 64'd0);
        RST_N = 1'b0;
        #1;
        chk("t6_rst_empty", 64'(FIFO_EMPTY), 64'd1);
        chk("t6_rst_ts", 64'(TIMESTAMP), 64'd0);
        chk("t6_rst_lost", 64'(LOST_COUNT), 64'd0);
        chk("t6_rst_data", 64'(FIFO_DATA), 64'd0);
        sb.delete();
        exp_evt  = 0;
        exp_lost = 0;
        @(negedge CLK);
        RST_N = 1'b1;
        step(3);
        chk("t6_ts_after", 64'(TIMESTAMP), 64'(tb_ts));
        pulse(6, 10, 1'b1);
        chk("t6_evt0_field", 64'(sb[2][25:16]), 64'd0);
        drain(50);
        chk("t6_lost_end", 64'(LOST_COUNT), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
